// File: rtl/activation_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// act_sched_pkg
// Shared definitions for the softsign denominator scheduler:
//   state_t          - scheduler FSM encoding (2 bits)
//   DEFAULT_TIMEOUT  - default watchdog length in WAIT cycles
//   act_idw()        - width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package act_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 16;

    // A single requester still needs a 1-bit index field.
    function automatic int act_idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/activation_scheduler_if.sv
// ---------------------------------------------------------------------------
// act_sched_if
// Bundles the neuron-side request/ack bus and the denominator-unit handshake.
//   req, x_in            requesters -> scheduler (level request + operands)
//   ack, result,
//   result_id            scheduler -> requesters (1-cycle ack, held result)
//   busy, err_timeout    scheduler status
//   unit_start, unit_x   scheduler -> denominator unit
//   unit_done,
//   unit_denom           denominator unit -> scheduler
// Modports:
//   master - the environment (neuron array + denominator unit)
//   slave  - the scheduler
// ---------------------------------------------------------------------------
interface act_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
) ();
    import act_sched_pkg::*;

    localparam int IDW = act_idw(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] x_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      result;
    logic [IDW-1:0]    result_id;
    logic              busy;
    logic              err_timeout;
    logic              unit_start;
    logic [W-1:0]      unit_x;
    logic              unit_done;
    logic [W-1:0]      unit_denom;

    modport master (
        output req, x_in, unit_done, unit_denom,
        input  ack, result, result_id, busy, err_timeout, unit_start, unit_x
    );

    modport slave (
        input  req, x_in, unit_done, unit_denom,
        output ack, result, result_id, busy, err_timeout, unit_start, unit_x
    );

endinterface

// File: rtl/activation_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches i_ptr+1, i_ptr+2, ... (mod
// NREQ) and returns the first requester found.
//   i_req       in   NREQ  request vector
//   i_ptr       in   IDW   last served requester
//   o_grant_id  out  IDW   selected requester (0 when none)
//   o_any       out  1     at least one request pending
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_grant_id,
    output logic            o_any
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_any      = |i_req;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        // k runs to NREQ so the last served requester is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant_id = IDW'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/activation_scheduler.sv
// ---------------------------------------------------------------------------
// activation_scheduler
// Time-shares one denominator unit (1+|X|) among NREQ softsign neurons.
// A requester is picked round-robin, its operand is launched on the unit,
// the one-cycle result is captured and returned with a one-cycle ack.
// A watchdog aborts an operation whose unit_done never arrives.
//   CLOCK   in  clock, rising edge
//   reset   in  synchronous, active-high
//   bus     act_sched_if.slave (request/ack bus + unit handshake)
// ---------------------------------------------------------------------------
module activation_scheduler
    import act_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLOCK,
    input  logic        reset,
    act_sched_if.slave  bus
);

    localparam int IDW = act_idw(NREQ);

    state_t            r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [7:0]        r_wdog;
    logic [NREQ-1:0]   r_ack;
    logic [W-1:0]      r_result;
    logic [IDW-1:0]    r_result_id;
    logic              r_busy;
    logic              r_err;
    logic              r_unit_start;
    logic [W-1:0]      r_unit_x;

    logic [IDW-1:0]    w_grant_id;
    logic              w_any;
    logic [W-1:0]      w_x_sel;
    logic [NREQ-1:0]   w_id_onehot;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req      (bus.req),
        .i_ptr      (r_ptr),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    // Operand of the requester the picker currently selects.
    always_comb begin
        w_x_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_id == IDW'(i)) begin
                w_x_sel = bus.x_in[i*W +: W];
            end
        end
    end

    assign w_id_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_id;

    // All outputs are registered: each is written on the edge that enters
    // the state in which it must be visible.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_wdog       <= '0;
            r_ack        <= '0;
            r_result     <= '0;
            r_result_id  <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_unit_start <= 1'b0;
            r_unit_x     <= '0;
        end else begin
            r_ack        <= '0;
            r_unit_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id         <= w_grant_id;
                        r_unit_x     <= w_x_sel;
                        r_unit_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // unit_x stays put: the unit keeps reading it after start.
                    if (bus.unit_done) begin
                        // Done wins even in the watchdog expiry cycle.
                        r_result    <= bus.unit_denom;
                        r_ack       <= w_id_onehot;
                        r_result_id <= r_id;
                        r_state     <= S_DELIVER;
                    end else if (r_wdog == 8'(TIMEOUT - 1)) begin
                        r_result    <= '0;
                        r_err       <= 1'b1;
                        r_ack       <= w_id_onehot;
                        r_result_id <= r_id;
                        r_state     <= S_DELIVER;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                S_DELIVER: begin
                    r_ptr   <= r_id;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack         = r_ack;
    assign bus.result      = r_result;
    assign bus.result_id   = r_result_id;
    assign bus.busy        = r_busy;
    assign bus.err_timeout = r_err;
    assign bus.unit_start  = r_unit_start;
    assign bus.unit_x      = r_unit_x;

endmodule

// File: tb/tb_activation_scheduler.sv
// ---------------------------------------------------------------------------
// tb_activation_scheduler
// Scheduler paired with a behavioural denominator unit (normal, never-done
// and done-at-watchdog-expiry modes). A transaction-level reference model
// predicts every grant, ack, result and status output cycle by cycle.
// ---------------------------------------------------------------------------
module tb_activation_scheduler;
    import act_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int IDW     = $clog2(NREQ);

    logic CLOCK = 1'b0;
    logic rst;
    always #5 CLOCK = ~CLOCK;

    act_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    activation_scheduler #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLOCK (CLOCK),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_denom(input logic [W-1:0] x);
        longint v;
        v = $signed(x);
        if (v < 0) v = -v;
        return W'(v + 1);
    endfunction

    // ---------------- denominator unit (behavioural) ----------------
    // mode 0: done 3 cycles after the start cycle; 1: never; 2: done in the
    // watchdog expiry cycle.
    int unit_mode = 0;
    int ucnt;
    logic signed [W-1:0] usx;
    always @(posedge CLOCK) begin
        if (rst) begin
            ucnt           <= 0;
            bus.unit_done  <= 1'b0;
            bus.unit_denom <= '0;
        end else begin
            bus.unit_done  <= 1'b0;
            bus.unit_denom <= '0;
            if (bus.unit_start) begin
                ucnt <= 1;
            end else if (ucnt != 0) begin
                if (unit_mode != 1 && ucnt == ((unit_mode == 0) ? 3 : TIMEOUT) - 1) begin
                    usx = bus.unit_x;
                    bus.unit_done  <= 1'b1;
                    bus.unit_denom <= (usx[W-1] ? -usx : usx) + 1;
                    ucnt <= 0;
                end else begin
                    ucnt <= ucnt + 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          edge_n;
        int          id;
        logic [W-1:0] res;
        logic        err;
    } exp_t;
    exp_t expq[$];

    int e = 0;                  // number of rising edges so far
    int next_free = 0;
    int m_ptr = NREQ - 1;
    int cur_g = -100, cur_end = -100;
    int m_id, m_c, m_lat;
    logic [W-1:0]    m_x;
    logic [NREQ-1:0] exp_ack;
    logic [W-1:0]    exp_result, exp_ux;
    logic [IDW-1:0]  exp_rid;
    logic            exp_busy, exp_err, exp_start;

    always @(posedge CLOCK) begin
        e++;
        exp_ack = '0;
        if (rst) begin
            expq.delete();
            m_ptr = NREQ - 1;
            next_free = e + 1;
            cur_g = -100; cur_end = -100;
            exp_result = '0; exp_rid = '0; exp_err = 1'b0; exp_ux = '0;
        end else begin
            if (e >= next_free && bus.req != '0) begin
                m_id = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    m_c = (m_ptr + k) % NREQ;
                    if (m_id < 0 && bus.req[m_c]) m_id = m_c;
                end
                m_x   = bus.x_in[m_id*W +: W];
                m_lat = (unit_mode == 0) ? 4 : TIMEOUT + 1;
                expq.push_back('{e + m_lat, m_id, (unit_mode == 1) ? '0 : ref_denom(m_x), unit_mode == 1});
                cur_g = e; cur_end = e + m_lat;
                next_free = e + m_lat + 2;
                m_ptr = m_id;
                exp_ux = m_x;
            end
            if (expq.size() > 0 && expq[0].edge_n == e) begin
                exp_ack    = NREQ'(1) << expq[0].id;
                exp_result = expq[0].res;
                exp_rid    = IDW'(expq[0].id);
                if (expq[0].err) exp_err = 1'b1;
                void'(expq.pop_front());
            end
        end
        exp_busy  = !rst && (e >= cur_g) && (e <= cur_end);
        exp_start = !rst && (e == cur_g);
    end

    // ---------------- output checker ----------------
    typedef struct {
        int          edge_n;
        int          id;
        logic [W-1:0] res;
    } ack_t;
    ack_t ackq[$];

    always @(negedge CLOCK) begin
        if (e > 0) begin
            check("ack",        bus.ack,         exp_ack);
            check("result",     bus.result,      exp_result);
            check("result_id",  bus.result_id,   exp_rid);
            check("busy",       bus.busy,        exp_busy);
            check("err",        bus.err_timeout, exp_err);
            check("unit_start", bus.unit_start,  exp_start);
            check("unit_x",     bus.unit_x,      exp_ux);
            for (int i = 0; i < NREQ; i++)
                if (bus.ack[i]) ackq.push_back('{e, i, bus.result});
        end
    end

    // ---------------- stimulus ----------------
    logic auto_drop = 1'b1;

    task automatic step();
        @(negedge CLOCK);
        #1;
        if (auto_drop) bus.req = bus.req & ~bus.ack;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k = 0;
        while (ackq.size() < target && k < budget) begin
            step();
            k++;
        end
        check("ack_arrived", 64'(ackq.size() >= target), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_x(input int i, input logic [W-1:0] x);
        bus.x_in[i*W +: W] = x;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    int base, s;
    logic [W-1:0] xv [3];
    logic [W-1:0] rv [3];

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.x_in = '0;
        repeat (3) step();
        check("rst_busy",  bus.busy, 0);
        check("rst_ack",   bus.ack, 0);
        check("rst_ux",    bus.unit_x, 0);
        check("rst_err",   bus.err_timeout, 0);
        rst = 1'b0;
        step();

        // 1: single request, latency and result
        base = ackq.size();
        set_x(0, 32'd5); bus.req = 4'b0001; s = e + 1;
        wait_acks(base + 1, 20);
        if (ackq.size() > base) begin
            check("t1_latency", ackq[base].edge_n - s, 4);
            check("t1_id",      ackq[base].id, 0);
            check("t1_result",  ackq[base].res, 6);
        end
        step(); step();

        // 2: negative, zero, wrap
        xv[0] = 32'hFFFF_FFFD; xv[1] = 32'h0; xv[2] = 32'h7FFF_FFFF;
        rv[0] = 32'd4;         rv[1] = 32'd1; rv[2] = 32'h8000_0000;
        for (int j = 0; j < 3; j++) begin
            base = ackq.size();
            set_x(0, xv[j]); bus.req = 4'b0001;
            wait_acks(base + 1, 20);
            if (ackq.size() > base) check("t2_result", ackq[base].res, rv[j]);
            step();
        end

        // 3: all requesting, fair order from reset pointer
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < NREQ; i++) set_x(i, W'(i * 10));
        base = ackq.size();
        bus.req = 4'b1111;
        wait_acks(base + 5, 60);
        bus.req = '0;
        auto_drop = 1'b1;
        if (ackq.size() >= base + 5) begin
            for (int j = 0; j < 5; j++) begin
                check("t3_id",     ackq[base+j].id, j % 4);
                check("t3_result", ackq[base+j].res, (j % 4) * 10 + 1);
                if (j > 0) check("t3_spacing", ackq[base+j].edge_n - ackq[base+j-1].edge_n, 6);
            end
        end
        repeat (8) step();

        // 4: pointer fairness
        base = ackq.size();
        set_x(1, 32'd100); bus.req = 4'b0010;
        wait_acks(base + 1, 20);
        step();
        set_x(1, 32'd7); set_x(2, 32'd8);
        bus.req = 4'b0110;
        wait_acks(base + 3, 40);
        if (ackq.size() >= base + 3) begin
            check("t4_first",  ackq[base+1].id, 2);
            check("t4_second", ackq[base+2].id, 1);
        end
        repeat (3) step();

        // 5: watchdog abort, sticky error, then done-at-expiry
        unit_mode = 1;
        base = ackq.size();
        set_x(0, 32'd7); bus.req = 4'b0001; s = e + 1;
        wait_acks(base + 1, 60);
        if (ackq.size() > base) begin
            check("t5_to_latency", ackq[base].edge_n - s, TIMEOUT + 1);
            check("t5_to_result",  ackq[base].res, 0);
        end
        step();
        check("t5_err_sticky", bus.err_timeout, 1);
        unit_mode = 0;
        bus.req = 4'b0001;
        wait_acks(base + 2, 20);
        step();
        check("t5_err_kept", bus.err_timeout, 1);
        do_reset();
        check("t5_err_clear", bus.err_timeout, 0);
        unit_mode = 2;
        base = ackq.size();
        set_x(2, 32'd9); bus.req = 4'b0100; s = e + 1;
        wait_acks(base + 1, 60);
        if (ackq.size() > base) begin
            check("t5_exp_latency", ackq[base].edge_n - s, TIMEOUT + 1);
            check("t5_exp_result",  ackq[base].res, 10);
        end
        step();
        check("t5_exp_noerr", bus.err_timeout, 0);
        unit_mode = 0;
        step();

        // 6: reset during WAIT, then normal service
        set_x(2, 32'd3); bus.req = 4'b0100;
        step(); step(); step();
        base = ackq.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy", bus.busy, 0);
        check("t6_ack",  bus.ack, 0);
        check("t6_ux",   bus.unit_x, 0);
        wait_acks(base + 1, 20);
        if (ackq.size() > base) begin
            check("t6_id",     ackq[base].id, 2);
            check("t6_result", ackq[base].res, 4);
        end
        step();

        // 7: request dropped after grant still acked
        base = ackq.size();
        set_x(3, 32'd20); bus.req = 4'b1000;
        step(); step();
        bus.req = '0;
        wait_acks(base + 1, 20);
        if (ackq.size() > base) begin
            check("t7_id",     ackq[base].id, 3);
            check("t7_result", ackq[base].res, 21);
        end
        repeat (3) step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if (!bus.busy && $urandom_range(0, 19) == 0)
                unit_mode = ($urandom_range(0, 9) == 0) ? (1 + $urandom_range(0, 1)) : 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i]) begin
                    case ($urandom_range(0, 3))
                        0: set_x(i, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
                        1: begin set_x(i, $urandom); bus.req[i] = 1'b1; end
                        default: ;
                    endcase
                end
            end
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        bus.req = '0;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
